mips_mc_ctrl: RTL and testbench

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

---
 rtl/mips_mc_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch, decode, ALU, memory and writeback
// steps, holding each ALU step for ALU_LAT+1 cycles so registered results can settle.
package ALU_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SHL = 4'd5,
        ALU_SHR = 4'd6,
        ALU_MUL = 4'd7
    } ALU_ctrl_e;
endpackage

module mips_mc_ctrl
    import ALU_pkg::*;
#(
    parameter int ALU_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero_f,
    input  logic       mem_ready,
    output ALU_ctrl_e  alu_ctrl,
    output logic       alu_en,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       target_write,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_PCINC   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_MEMADR  = 4'd3;
    localparam logic [3:0] S_MEMRD   = 4'd4;
    localparam logic [3:0] S_MEMWB   = 4'd5;
    localparam logic [3:0] S_MEMWR   = 4'd6;
    localparam logic [3:0] S_RTEXEC  = 4'd7;
    localparam logic [3:0] S_RTWB    = 4'd8;
    localparam logic [3:0] S_BEQ     = 4'd9;
    localparam logic [3:0] S_ADDIEX  = 4'd10;
    localparam logic [3:0] S_ADDIWB  = 4'd11;
    localparam logic [3:0] S_JUMP    = 4'd12;
    localparam logic [3:0] S_ILLEGAL = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_alu, last;
    logic          rt_ok;
    ALU_ctrl_e     rt_op;

    ALU_ctrl_e  ctrl_c;
    logic       alu_en_c, src_a_c, pc_write_c, target_write_c;
    logic [1:0] src_b_c, pc_src_c;
    logic       mem_req_c, mem_we_c, iord_c, ir_write_c;
    logic       reg_write_c, reg_dst_c, mem_to_reg_c, illegal_c;

    always_comb begin
        rt_ok = 1'b1;
        rt_op = ALU_ADD;
        case (funct)
            6'b100000: rt_op = ALU_ADD;
            6'b100010: rt_op = ALU_SUB;
            6'b100100: rt_op = ALU_AND;
            6'b100101: rt_op = ALU_OR;
            6'b100110: rt_op = ALU_XOR;
            6'b000000: rt_op = ALU_SHL;
            6'b000010: rt_op = ALU_SHR;
            6'b011000: rt_op = ALU_MUL;
            default:   rt_ok = 1'b0;
        endcase
    end

    assign is_alu = (state_q == S_PCINC)  || (state_q == S_DECODE) ||
                    (state_q == S_MEMADR) || (state_q == S_RTEXEC) ||
                    (state_q == S_BEQ)    || (state_q == S_ADDIEX);
    assign last   = (cnt_q == CW'(ALU_LAT));

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (is_alu && !last) cnt_d = cnt_q + CW'(1);
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_PCINC;
            S_PCINC:  if (last) state_d = S_DECODE;
            S_DECODE: if (last) begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = rt_ok ? S_RTEXEC : S_ILLEGAL;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: if (last) state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_RTEXEC: if (last) state_d = S_RTWB;
            S_BEQ:    if (last) state_d = S_FETCH;
            S_ADDIEX: if (last) state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        ctrl_c         = ALU_ADD;
        alu_en_c       = 1'b0;
        src_a_c        = 1'b0;
        src_b_c        = 2'b00;
        pc_write_c     = 1'b0;
        pc_src_c       = 2'b00;
        target_write_c = 1'b0;
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        iord_c         = 1'b0;
        ir_write_c     = 1'b0;
        reg_write_c    = 1'b0;
        reg_dst_c      = 1'b0;
        mem_to_reg_c   = 1'b0;
        illegal_c      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_c  = 1'b1;
                ir_write_c = mem_ready;
            end
            S_PCINC: begin
                alu_en_c   = 1'b1;
                src_b_c    = 2'b01;
                pc_write_c = last;
            end
            S_DECODE: begin
                alu_en_c       = 1'b1;
                src_b_c        = 2'b11;
                target_write_c = last;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_en_c = 1'b1;
                src_a_c  = 1'b1;
                src_b_c  = 2'b10;
            end
            S_MEMRD: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
            end
            S_MEMWR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                iord_c    = 1'b1;
            end
            S_MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
            end
            S_RTEXEC: begin
                alu_en_c = 1'b1;
                ctrl_c   = rt_op;
                src_a_c  = 1'b1;
            end
            S_RTWB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
            end
            // Branch decision uses the zero flag only once the subtract result is valid.
            S_BEQ: begin
                alu_en_c   = 1'b1;
                ctrl_c     = ALU_SUB;
                src_a_c    = 1'b1;
                pc_write_c = last & zero_f;
                pc_src_c   = last ? 2'b01 : 2'b00;
            end
            S_ADDIWB: reg_write_c = 1'b1;
            S_JUMP: begin
                pc_write_c = 1'b1;
                pc_src_c   = 2'b10;
            end
            S_ILLEGAL: illegal_c = 1'b1;
            default: ;
        endcase
    end

    // Outputs are squelched while reset is held so no strobe leaks out of FETCH.
    assign alu_ctrl     = rst_n ? ctrl_c : ALU_ADD;
    assign alu_en       = rst_n & alu_en_c;
    assign alu_src_a    = rst_n & src_a_c;
    assign alu_src_b    = rst_n ? src_b_c : 2'b00;
    assign pc_write     = rst_n & pc_write_c;
    assign pc_src       = rst_n ? pc_src_c : 2'b00;
    assign target_write = rst_n & target_write_c;
    assign mem_req      = rst_n & mem_req_c;
    assign mem_we       = rst_n & mem_we_c;
    assign iord         = rst_n & iord_c;
    assign ir_write     = rst_n & ir_write_c;
    assign reg_write    = rst_n & reg_write_c;
    assign reg_dst      = rst_n & reg_dst_c;
    assign mem_to_reg   = rst_n & mem_to_reg_c;
    assign illegal      = rst_n & illegal_c;
    assign state        = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: expands each instruction into its expected per-cycle
// output trace and compares both an ALU_LAT=2 and an ALU_LAT=4 instance against it.
module tb_mips_mc_ctrl;
    import ALU_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       alu_en;
        logic [3:0] ctrl;
        logic       sa;
        logic [1:0] sb;
        logic       pcw;
        logic [1:0] pcs;
        logic       tw;
        logic       mreq;
        logic       mwe;
        logic       iord;
        logic       irw;
        logic       rw;
        logic       rd;
        logic       m2r;
        logic       ill;
    } outs_t;

    typedef struct packed {
        logic  mr;
        logic  zf;
        outs_t o;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst2_n, rst4_n, zero_f, mem_ready;
    logic [5:0] opcode, funct;

    ALU_ctrl_e  ctrl2, ctrl4;
    logic       en2, en4, sa2, sa4, pcw2, pcw4, tw2, tw4, mreq2, mreq4, mwe2, mwe4;
    logic       iord2, iord4, irw2, irw4, rw2, rw4, rd2, rd4, m2r2, m2r4, ill2, ill4;
    logic [1:0] sb2, sb4, pcs2, pcs4;
    logic [3:0] st2, st4;

    mips_mc_ctrl #(.ALU_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .opcode(opcode), .funct(funct), .zero_f(zero_f),
        .mem_ready(mem_ready), .alu_ctrl(ctrl2), .alu_en(en2), .alu_src_a(sa2),
        .alu_src_b(sb2), .pc_write(pcw2), .pc_src(pcs2), .target_write(tw2),
        .mem_req(mreq2), .mem_we(mwe2), .iord(iord2), .ir_write(irw2),
        .reg_write(rw2), .reg_dst(rd2), .mem_to_reg(m2r2), .illegal(ill2), .state(st2)
    );

    mips_mc_ctrl #(.ALU_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .opcode(opcode), .funct(funct), .zero_f(zero_f),
        .mem_ready(mem_ready), .alu_ctrl(ctrl4), .alu_en(en4), .alu_src_a(sa4),
        .alu_src_b(sb4), .pc_write(pcw4), .pc_src(pcs4), .target_write(tw4),
        .mem_req(mreq4), .mem_we(mwe4), .iord(iord4), .ir_write(irw4),
        .reg_write(rw4), .reg_dst(rd4), .mem_to_reg(m2r4), .illegal(ill4), .state(st4)
    );

    outs_t a2, a4;
    assign a2 = {st2, en2, ctrl2, sa2, sb2, pcw2, pcs2, tw2, mreq2, mwe2, iord2, irw2, rw2, rd2, m2r2, ill2};
    assign a4 = {st4, en4, ctrl4, sa4, sb4, pcw4, pcs4, tw4, mreq4, mwe4, iord4, irw4, rw4, rd4, m2r4, ill4};

    int   checks = 0;
    int   errors = 0;
    bit   sel4   = 1'b0;
    rec_t q[$];

    task automatic check(input string nm, input outs_t e);
        outs_t a;
        a = sel4 ? a4 : a2;
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t: got st=%0d vec=%h, expected st=%0d vec=%h",
                     nm, $time, a.st, a, e.st, e);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic outs_t idle(input logic [3:0] st);
        outs_t o;
        o      = '0;
        o.st   = st;
        o.ctrl = ALU_ADD;
        return o;
    endfunction

    task automatic rt_map(input logic [5:0] fn, output bit ok, output logic [3:0] op);
        ok = 1'b1;
        case (fn)
            6'b100000: op = ALU_ADD;
            6'b100010: op = ALU_SUB;
            6'b100100: op = ALU_AND;
            6'b100101: op = ALU_OR;
            6'b100110: op = ALU_XOR;
            6'b000000: op = ALU_SHL;
            6'b000010: op = ALU_SHR;
            6'b011000: op = ALU_MUL;
            default: begin ok = 1'b0; op = ALU_ADD; end
        endcase
    endtask

    // kind: 0 none, 1 PC+4 write on last, 2 target write on last, 3 branch on last
    task automatic alu_phase(input int L, input logic [3:0] st, input logic [3:0] op,
                             input logic sa, input logic [1:0] sb, input int kind,
                             input logic zf, input logic stray);
        for (int c = 0; c <= L; c++) begin
            rec_t r;
            bit   lst;
            lst       = (c == L);
            r.mr      = stray;
            r.zf      = 1'b0;
            r.o       = idle(st);
            r.o.alu_en = 1'b1;
            r.o.ctrl  = op;
            r.o.sa    = sa;
            r.o.sb    = sb;
            if (kind == 1) r.o.pcw = lst;
            if (kind == 2) r.o.tw  = lst;
            if (kind == 3) begin
                r.zf    = lst ? zf : ~zf;
                r.o.pcw = lst & zf;
                r.o.pcs = lst ? 2'b01 : 2'b00;
            end
            q.push_back(r);
        end
    endtask

    task automatic one(input outs_t o);
        rec_t r;
        r.mr = 1'b0;
        r.zf = 1'b0;
        r.o  = o;
        q.push_back(r);
    endtask

    task automatic mem_wait(input logic [3:0] st, input int d, input logic we, input logic io);
        for (int i = 0; i <= d; i++) begin
            rec_t r;
            r.mr     = (i == d);
            r.zf     = 1'b0;
            r.o      = idle(st);
            r.o.mreq = 1'b1;
            r.o.mwe  = we;
            r.o.iord = io;
            r.o.irw  = (st == 4'd0) && (i == d);
            q.push_back(r);
        end
    endtask

    task automatic expand(input int L, input logic [5:0] op, input logic [5:0] fn,
                          input int fd, input int md, input logic zf, input logic stray);
        bit         ok;
        logic [3:0] rop;
        outs_t      o;
        q.delete();
        mem_wait(4'd0, fd, 1'b0, 1'b0);
        alu_phase(L, 4'd1, ALU_ADD, 1'b0, 2'b01, 1, 1'b0, stray);
        alu_phase(L, 4'd2, ALU_ADD, 1'b0, 2'b11, 2, 1'b0, stray);
        rt_map(fn, ok, rop);
        if (op == 6'b100011 || op == 6'b101011) begin
            alu_phase(L, 4'd3, ALU_ADD, 1'b1, 2'b10, 0, 1'b0, stray);
            if (op == 6'b100011) begin
                mem_wait(4'd4, md, 1'b0, 1'b1);
                o = idle(4'd5); o.rw = 1'b1; o.m2r = 1'b1; one(o);
            end else begin
                mem_wait(4'd6, md, 1'b1, 1'b1);
            end
        end else if (op == 6'b000000 && ok) begin
            alu_phase(L, 4'd7, rop, 1'b1, 2'b00, 0, 1'b0, stray);
            o = idle(4'd8); o.rw = 1'b1; o.rd = 1'b1; one(o);
        end else if (op == 6'b000100) begin
            alu_phase(L, 4'd9, ALU_SUB, 1'b1, 2'b00, 3, zf, stray);
        end else if (op == 6'b001000) begin
            alu_phase(L, 4'd10, ALU_ADD, 1'b1, 2'b10, 0, 1'b0, stray);
            o = idle(4'd11); o.rw = 1'b1; one(o);
        end else if (op == 6'b000010) begin
            o = idle(4'd12); o.pcw = 1'b1; o.pcs = 2'b10; one(o);
        end else begin
            o = idle(4'd13); o.ill = 1'b1; one(o);
        end
    endtask

    function automatic int count_st(input logic [3:0] st);
        int n = 0;
        foreach (q[i]) if (q[i].o.st == st) n++;
        return n;
    endfunction

    function automatic int count_pcw_after_pcinc();
        int n = 0;
        foreach (q[i]) if (q[i].o.pcw && q[i].o.st != 4'd1) n++;
        return n;
    endfunction

    function automatic int count_rw();
        int n = 0;
        foreach (q[i]) if (q[i].o.rw) n++;
        return n;
    endfunction

    // Entered at a falling edge; leaves at the falling edge where FETCH is current again.
    task automatic play(input string nm);
        while (q.size() != 0) begin
            rec_t r;
            r = q.pop_front();
            mem_ready = r.mr;
            zero_f    = r.zf;
            #1;
            check(nm, r.o);
            @(negedge clk);
        end
        mem_ready = 1'b0;
        zero_f    = 1'b0;
    endtask

    task automatic run(input string nm, input int L, input logic [5:0] op, input logic [5:0] fn,
                       input int fd, input int md, input logic zf, input logic stray);
        expand(L, op, fn, fd, md, zf, stray);
        opcode = op;
        funct  = fn;
        play(nm);
    endtask

    initial begin
        rst2_n = 1'b0; rst4_n = 1'b0; zero_f = 1'b0; mem_ready = 1'b0;
        opcode = 6'd0; funct = 6'd0;
        #2;
        check("reset_l2", idle(4'd0));
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("reset_ignores_ready", idle(4'd0));
        mem_ready = 1'b0;
        @(negedge clk);
        rst2_n = 1'b1;

        expand(2, 6'b000000, 6'b100000, 0, 0, 1'b0, 1'b0);
        check_int("add_l2_cycles", q.size(), 11);
        check_int("add_l2_rw", count_rw(), 1);
        opcode = 6'b000000; funct = 6'b100000;
        play("add_l2");

        expand(2, 6'b100011, 6'd0, 2, 3, 1'b0, 1'b0);
        check_int("lw_memrd_cycles", count_st(4'd4), 4);
        opcode = 6'b100011; funct = 6'd0;
        play("lw_l2");

        run("sw_l2",  2, 6'b101011, 6'd0,       1, 0, 1'b0, 1'b0);

        expand(2, 6'b000100, 6'd0, 0, 0, 1'b1, 1'b0);
        check_int("beq_taken_pcw", count_pcw_after_pcinc(), 1);
        opcode = 6'b000100; funct = 6'd0;
        play("beq_taken");

        expand(2, 6'b000100, 6'd0, 0, 0, 1'b0, 1'b0);
        check_int("beq_not_taken_pcw", count_pcw_after_pcinc(), 0);
        opcode = 6'b000100; funct = 6'd0;
        play("beq_not_taken");

        run("addi_stray", 2, 6'b001000, 6'd0,       0, 0, 1'b0, 1'b1);
        run("jump",       2, 6'b000010, 6'd0,       0, 0, 1'b0, 1'b0);

        expand(2, 6'b111111, 6'd0, 0, 0, 1'b0, 1'b0);
        check_int("ill_op_cycles", q.size(), 8);
        check_int("ill_op_rw", count_rw(), 0);
        opcode = 6'b111111; funct = 6'd0;
        play("illegal_op");

        run("illegal_funct", 2, 6'b000000, 6'b001000, 0, 0, 1'b0, 1'b0);
        run("sub",  2, 6'b000000, 6'b100010, 1, 0, 1'b0, 1'b0);
        run("sll",  2, 6'b000000, 6'b000000, 0, 0, 1'b0, 1'b0);
        run("srl",  2, 6'b000000, 6'b000010, 0, 0, 1'b0, 1'b0);
        run("mul",  2, 6'b000000, 6'b011000, 0, 0, 1'b0, 1'b0);
        run("or",   2, 6'b000000, 6'b100101, 0, 0, 1'b0, 1'b0);

        // Reset asserted during RTEXEC with cnt==1.
        begin
            int rt_seen = 0;
            bit hit     = 1'b0;
            expand(2, 6'b000000, 6'b100100, 0, 0, 1'b0, 1'b0);
            opcode = 6'b000000; funct = 6'b100100;
            while (q.size() != 0 && !hit) begin
                rec_t r;
                r = q.pop_front();
                mem_ready = r.mr;
                zero_f    = r.zf;
                #1;
                check("and_pre_reset", r.o);
                if (r.o.st == 4'd7) rt_seen++;
                if (rt_seen == 2) begin
                    hit    = 1'b1;
                    rst2_n = 1'b0;
                    #1;
                    check("reset_mid_rtexec", idle(4'd0));
                end
                @(negedge clk);
            end
            check_int("reset_point_reached", int'(hit), 1);
            #1;
            check("reset_held", idle(4'd0));
            q.delete();
            @(negedge clk);
            rst2_n = 1'b1;
        end
        run("xor_after_reset", 2, 6'b000000, 6'b100110, 0, 0, 1'b0, 1'b0);

        rst2_n = 1'b0;
        sel4   = 1'b1;
        #1;
        check("reset_l4", idle(4'd0));
        @(negedge clk);
        rst4_n = 1'b1;
        expand(4, 6'b000000, 6'b100000, 0, 0, 1'b0, 1'b0);
        check_int("add_l4_cycles", q.size(), 17);
        check_int("add_l4_rtexec", count_st(4'd7), 5);
        opcode = 6'b000000; funct = 6'b100000;
        play("add_l4");
        run("beq_l4", 4, 6'b000100, 6'd0,       0, 0, 1'b1, 1'b0);
        run("lw_l4",  4, 6'b100011, 6'd0,       1, 2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
